// File: rtl/c432_test_pkg.sv
// c432_test_pkg: shared state encoding, widths, tap positions and step functions for the c432 self-test sequencer
package c432_test_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;
  localparam int LFSR_W = 36;
  localparam int RESP_W = 7;
  localparam int SIG_W = 16;
  localparam int LFSR_TAP_A = 35;
  localparam int LFSR_TAP_B = 10;
  localparam int MISR_TAP_A = 15;
  localparam int MISR_TAP_B = 14;
  localparam int MISR_TAP_C = 12;
  localparam int MISR_TAP_D = 3;
  localparam logic [LFSR_W-1:0] ZERO_SEED = 36'h1;
  // x^36 + x^11 + 1
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
  endfunction
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m, input logic [RESP_W-1:0] d);
    return {m[SIG_W-2:0], m[MISR_TAP_A] ^ m[MISR_TAP_B] ^ m[MISR_TAP_C] ^ m[MISR_TAP_D]}
           ^ {{(SIG_W-RESP_W){1'b0}}, d};
  endfunction
endpackage

// File: rtl/c432_misr.sv
// c432_misr: 16-bit multiple-input signature register compressing 7-bit responses
//   clk/rst_n : clock, synchronous active-low reset
//   clr       : zero the signature (wins over en)
//   en        : fold data into the signature this edge
//   data      : response word
//   sig       : current signature; sig_nxt : value sig takes on an enabled edge
module c432_misr
  import c432_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] data,
  output logic [SIG_W-1:0]  sig,
  output logic [SIG_W-1:0]  sig_nxt
);
  assign sig_nxt = misr_step(sig, data);
  always_ff @(posedge clk) begin
    if (!rst_n || clr) sig <= '0;
    else if (en) sig <= sig_nxt;
  end
endmodule

// File: rtl/c432_test_sequencer.sv
// c432_test_sequencer: LFSR-driven self-test of the c432 wrapper with MISR signature compare
//   clk/rst_n           : clock, synchronous active-low reset
//   start/abort         : begin a run (IDLE/DONE only) / cancel a run in progress
//   seed/num_vec/golden_sig : run setup, latched on an accepted start
//   dut_in/dut_out      : vector to the wrapper / its response
//   busy/done/pass      : run status; pass is valid while done
//   signature/vec_count : current MISR value / vectors captured so far
module c432_test_sequencer
  import c432_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [SIG_W-1:0]  golden_sig,
  output logic [LFSR_W-1:0] dut_in,
  input  logic [RESP_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  vec_count
);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic [LFSR_W-1:0] lfsr, lfsr_n;
  logic [3:0] settle;
  logic [CNT_W-1:0] num_l;
  logic [SIG_W-1:0] gold_l, sig_nxt;
  logic accept, capture, last, enter_apply;
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    // abort suppresses the capture so signature and vec_count freeze for debug
    capture = state == CAPTURE && !abort;
    last = vec_count + CNT_W'(1) == num_l;
    state_n = state;
    case (state)
      IDLE, DONE: state_n = accept ? (num_vec == '0 ? DONE : APPLY) : state;
      APPLY:      state_n = abort ? IDLE : settle == SETTLE_LAST ? CAPTURE : APPLY;
      CAPTURE:    state_n = abort ? IDLE : last ? DONE : APPLY;
      default:    state_n = IDLE;
    endcase
    lfsr_n = accept ? (seed == '0 ? ZERO_SEED : seed) : capture ? lfsr_step(lfsr) : lfsr;
    // the wrapper input only moves when a new vector starts settling
    enter_apply = state_n == APPLY && state != APPLY;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= '0;
      dut_in <= '0;
      settle <= '0;
      num_l <= '0;
      gold_l <= '0;
      vec_count <= '0;
      pass <= 1'b0;
    end else begin
      lfsr <= lfsr_n;
      if (enter_apply) dut_in <= lfsr_n;
      settle <= (state == APPLY && state_n == APPLY) ? settle + 4'd1 : '0;
      if (accept) begin
        num_l <= num_vec;
        gold_l <= golden_sig;
        vec_count <= '0;
        pass <= num_vec == '0 && golden_sig == '0;
      end else if (capture) begin
        vec_count <= vec_count + CNT_W'(1);
        if (last) pass <= sig_nxt == gold_l;
      end
    end
  end
  c432_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (capture),
    .data   (dut_out),
    .sig    (signature),
    .sig_nxt(sig_nxt)
  );
  assign busy = state == APPLY || state == CAPTURE;
  assign done = state == DONE;
endmodule

// File: tb/tb_c432_test_sequencer.sv
// tb_c432_test_sequencer: randomized self-checking bench against a polynomial-level reference model
module tb_c432_test_sequencer;
  localparam int S = 2;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [35:0] seed = '0;
  logic [15:0] num_vec = '0, golden_sig = '0;
  logic [35:0] dut_in;
  logic [6:0] dut_out;
  logic busy, done, pass;
  logic [15:0] signature, vec_count;
  int checks = 0, errors = 0;
  int mode = 0;
  logic [6:0] tie = '0;
  always #5 clk = ~clk;
  c432_test_sequencer #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
    .num_vec(num_vec), .golden_sig(golden_sig), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .vec_count(vec_count)
  );
  // stand-in c432 wrapper: mode 0 tied, 1 clean XOR-fold, 2 same with a rare-trigger payload
  function automatic logic [6:0] wrap(input logic [35:0] v, input int md, input logic [6:0] t);
    logic [35:0] x;
    if (md == 0) return t;
    x = v ^ (v >> 7) ^ (v >> 14) ^ (v >> 21) ^ (v >> 28) ^ (v >> 35);
    if (md == 2 && (v & 36'h0000F00F0) == 36'h0000F00F0) x = x ^ 36'h40;
    return x[6:0];
  endfunction
  assign dut_out = wrap(dut_in, mode, tie);
  function automatic logic [35:0] m_lfsr(input logic [35:0] q);
    return (q << 1) | 36'(^(q & ((36'd1 << 35) | (36'd1 << 10))));
  endfunction
  function automatic logic [15:0] m_misr(input logic [15:0] m, input logic [6:0] d);
    return ((m << 1) | 16'(^(m & 16'hD008))) ^ 16'(d);
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic do_run(input logic [35:0] sd, input int nv, input logic [15:0] gs_in, input bit use_mg,
                        input int ab_at, input bit ab_final, input bit sa, input bit sb);
    logic [35:0] q, din0;
    logic [15:0] m, gs;
    logic [35:0] vq[$];
    logic [15:0] sq[$];
    int cyc, lim, idx, ab_idx;
    bit ab;
    q = (sd == 0) ? 36'h1 : sd;
    m = '0;
    sq.push_back(m);
    for (int i = 0; i < nv; i++) begin
      vq.push_back(q);
      m = m_misr(m, wrap(q, mode, tie));
      sq.push_back(m);
      q = m_lfsr(q);
    end
    gs = use_mg ? sq[nv] : gs_in;
    din0 = dut_in;
    @(negedge clk);
    seed = sd; num_vec = 16'(nv); golden_sig = gs; start = 1; abort = sa;
    @(negedge clk);
    start = 0; abort = 0; cyc = 1; lim = nv * (S + 1) + 1; ab = 0; ab_idx = 0;
    while (!done && cyc <= lim + 2) begin
      idx = int'(vec_count);
      chk("busy_run", 64'(busy), 1);
      chk("vec_range", 64'(idx < nv), 1);
      if (idx < nv) begin
        chk("dut_in_run", dut_in, vq[idx]);
        chk("sig_run", signature, sq[idx]);
      end
      start = (sb && cyc == 2);
      if (sb && cyc == 2) begin seed = ~sd; num_vec = 16'(nv + 5); end
      if ((ab_at >= 0 && idx == ab_at) || (ab_final && cyc == nv * (S + 1))) begin
        abort = 1; ab = 1; ab_idx = ab_final ? nv - 1 : ab_at;
      end
      @(negedge clk);
      cyc++;
      if (ab) begin
        abort = 0; start = 0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_vec", vec_count, 64'(ab_idx));
        chk("abort_sig", signature, sq[ab_idx]);
        return;
      end
    end
    start = 0;
    chk("latency", 64'(cyc), 64'(lim));
    chk("done", 64'(done), 1);
    chk("busy_done", 64'(busy), 0);
    chk("pass", 64'(pass), 64'(sq[nv] == gs));
    chk("sig_final", signature, sq[nv]);
    chk("vec_final", vec_count, 64'(nv));
    if (nv == 0) chk("dut_in_hold", dut_in, din0);
  endtask
  initial begin
    logic [63:0] r;
    int nv, ab_at;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_sig", signature, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_dut_in", dut_in, 0);
    rst_n = 1;
    mode = 0; tie = 7'h01;
    do_run(36'h1, 2, 16'h0003, 0, -1, 0, 0, 0);
    chk("t1_sig", signature, 16'h0003);
    chk("t1_pass", 64'(pass), 1);
    chk("t1_dut_in", dut_in, 36'h2);
    do_run(36'h1, 2, 16'h0004, 0, -1, 0, 1, 0);
    chk("t1b_pass", 64'(pass), 0);
    do_run(36'h0, 1, 16'h0, 0, -1, 0, 0, 0);
    chk("t2_dut_in", dut_in, 36'h1);
    chk("t2_vec", vec_count, 1);
    do_run(36'h5, 0, 16'h0, 0, -1, 0, 0, 0);
    chk("t3_sig", signature, 0);
    chk("t3_pass", 64'(pass), 1);
    mode = 1;
    do_run(36'hA5A5A5A5A, 1000, 16'h0, 1, -1, 0, 0, 0);
    chk("t4_pass_clean", 64'(pass), 1);
    golden_sig = signature;
    do_run(36'hA5A5A5A5A, 1000, signature, 0, -1, 0, 0, 0);
    mode = 2;
    do_run(36'hA5A5A5A5A, 1000, golden_sig, 0, -1, 0, 0, 0);
    mode = 1;
    do_run(36'h3C3C3C3C3, 10, 16'h0, 1, 5, 0, 0, 0);
    do_run(36'h123456789, 3, 16'h0, 1, -1, 1, 0, 0);
    do_run(36'h0F0F0F0F0, 6, 16'h0, 1, -1, 0, 0, 1);
    @(negedge clk);
    seed = 36'h123; num_vec = 16'd10; golden_sig = '0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    chk("mid_busy", 64'(busy), 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mrst_busy", 64'(busy), 0);
    chk("mrst_done", 64'(done), 0);
    chk("mrst_pass", 64'(pass), 0);
    chk("mrst_sig", signature, 0);
    chk("mrst_vec", vec_count, 0);
    chk("mrst_dut_in", dut_in, 0);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("idle_abort", 64'(busy | done), 0);
    for (int k = 0; k < 25; k++) begin
      r = {$urandom(), $urandom()};
      mode = int'($urandom_range(0, 2));
      tie = 7'($urandom());
      nv = int'($urandom_range(0, 12));
      ab_at = ($urandom_range(0, 3) == 0 && nv > 1) ? int'($urandom_range(0, nv - 1)) : -1;
      do_run(($urandom_range(0, 3) == 0) ? 36'h0 : r[35:0], nv, 16'($urandom()),
             1'($urandom_range(0, 1)), ab_at, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
